// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path, in-order
// word-by-word line refill over a valid/ready memory port, whole-cache flush.
module icache_dm #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] addr,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic        flush,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] miss_cnt
);
  localparam int OFF_W  = $clog2(WORDS) + 2;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int BEAT_W = $clog2(WORDS);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  logic [0:0]                       state;
  logic [LINES-1:0]                 line_vld;
  logic [LINES-1:0][TAG_W-1:0]      line_tag;
  logic [LINES-1:0][WORDS-1:0][31:0] line_data;

  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [BEAT_W-1:0] req_word, beat;
  logic              flush_pend, hit, miss, beat_fire, last_beat;
  logic              unused_addr;

  assign req_tag  = addr[31:IDX_W+OFF_W];
  assign req_idx  = addr[IDX_W+OFF_W-1:OFF_W];
  assign req_word = addr[OFF_W-1:2];
  assign unused_addr = ^addr[1:0];

  assign hit   = line_vld[req_idx] && (line_tag[req_idx] == req_tag) &&
                 (state == S_IDLE) && !flush;
  assign miss  = valid && !hit && !flush && (state == S_IDLE);
  assign ready = valid && hit;
  assign rdata = line_data[req_idx][req_word];

  // mem_valid only rises in REFILL, so a stray mem_ready in IDLE is ignored
  assign beat_fire = mem_valid && mem_ready;
  assign last_beat = beat_fire && (beat == BEAT_W'(WORDS-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      line_vld   <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      miss_cnt   <= '0;
      beat       <= '0;
      flush_pend <= 1'b0;
      fill_tag   <= '0;
      fill_idx   <= '0;
    end else begin
      // A flush arriving mid-refill also keeps the finishing line invalid
      if (flush)
        line_vld <= '0;
      else if (last_beat && !flush_pend)
        line_vld[fill_idx] <= 1'b1;

      case (state)
        S_IDLE: begin
          if (miss) begin
            state     <= S_REFILL;
            fill_tag  <= req_tag;
            fill_idx  <= req_idx;
            beat      <= '0;
            mem_valid <= 1'b1;
            mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
            if (miss_cnt != 32'hFFFF_FFFF)
              miss_cnt <= miss_cnt + 32'd1;
          end
        end
        default: begin
          if (flush)
            flush_pend <= 1'b1;
          if (beat_fire) begin
            beat     <= beat + BEAT_W'(1);
            mem_addr <= mem_addr + 32'd4;
          end
          if (last_beat) begin
            mem_valid  <= 1'b0;
            flush_pend <= 1'b0;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Line storage needs no reset: nothing is readable until its valid bit is set
  always_ff @(posedge clk) begin
    if (beat_fire)
      line_data[fill_idx][beat] <= mem_rdata;
    if (last_beat)
      line_tag[fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: table of fetches with a data scoreboard, plus
// hand sequences for wait states, flush and reset during refill.
module tb_icache_dm;
  localparam int WORDS = 4;
  localparam int ZW_STALL = WORDS + 1;

  logic        clk = 1'b0;
  logic        rst, valid, flush;
  logic [31:0] addr, rdata, mem_addr, mem_rdata, miss_cnt;
  logic        ready, mem_valid, mem_ready;

  int unsigned cyc = 0;
  int          wait_div = 1;
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] sb[$];

  icache_dm #(.LINES(64), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .rdata(rdata),
    .ready(ready), .flush(flush), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data is a fixed function of the word address; optional wait states
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;
  assign mem_ready = (wait_div <= 1) ? 1'b1 : ((cyc % wait_div) == 0);

  typedef struct {
    logic [31:0] a;
    int          stall;
    logic [31:0] d;
    logic [31:0] mc;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the served cycle.
  task automatic fetch(input logic [31:0] a, input int exp_stall,
                       input logic [31:0] exp_d, input logic [31:0] exp_mc);
    int stall = 0, beats = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] base, got;
    base  = a & ~32'hF;
    valid = 1'b1;
    addr  = a;
    sb.push_back(exp_d);
    forever begin
      @(negedge clk);
      if (ready) break;
      if (mem_valid) begin
        if (prev_stall) chk("mem_addr_stable", mem_addr, prev_addr);
        if (mem_ready) begin
          chk("beat_addr", mem_addr, base + 32'(4 * beats));
          beats++;
        end
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      stall++;
      if (stall > 200) begin
        nvec++; nerr++;
        $display("FAIL fetch_timeout: addr %h never served", a);
        break;
      end
    end
    got = sb.pop_front();
    chk("rdata", rdata, got);
    if (exp_stall >= 0) chk("stall_cycles", 32'(stall), 32'(exp_stall));
    if (exp_stall != 0) chk("beats", 32'(beats), 32'(WORDS));
    else                chk("mem_valid_on_hit", 32'(mem_valid), 32'd0);
    chk("miss_cnt", miss_cnt, exp_mc);
    @(posedge clk); #1;
  endtask

  initial begin
    int beats, n;
    tbl[0] = '{32'h0000_0104, ZW_STALL, 32'hA5A5_0104, 32'd1};
    tbl[1] = '{32'h0000_0100, 0,        32'hA5A5_0100, 32'd1};
    tbl[2] = '{32'h0000_0108, 0,        32'hA5A5_0108, 32'd1};
    tbl[3] = '{32'h0000_010C, 0,        32'hA5A5_010C, 32'd1};
    tbl[4] = '{32'h0000_0500, ZW_STALL, 32'hA5A5_0500, 32'd2};
    tbl[5] = '{32'h0000_0100, ZW_STALL, 32'hA5A5_0100, 32'd3};
    tbl[6] = '{32'h0000_0104, 0,        32'hA5A5_0104, 32'd3};

    // Reset with a request already pending
    rst = 1'b1; valid = 1'b1; addr = 32'h0000_0104; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss, same-line hits, conflict eviction
    for (int i = 0; i < 7; i++)
      fetch(tbl[i].a, tbl[i].stall, tbl[i].d, tbl[i].mc);

    // Wait states: mem_ready every third cycle
    wait_div = 3;
    fetch(32'h0000_0304, -1, 32'hA5A5_0304, 32'd4);
    wait_div = 1;
    fetch(32'h0000_0300, 0, 32'hA5A5_0300, 32'd4);
    fetch(32'h0000_0308, 0, 32'hA5A5_0308, 32'd4);
    fetch(32'h0000_030C, 0, 32'hA5A5_030C, 32'd4);

    // Flush in IDLE, coincident with a request to a valid line
    valid = 1'b1; addr = 32'h0000_0104; flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_no_refill", 32'(mem_valid), 32'd0);
    chk("flush_miss_cnt", miss_cnt, 32'd4);
    fetch(32'h0000_0104, ZW_STALL, 32'hA5A5_0104, 32'd5);

    // Flush on beat 1 of a refill for 0x200
    valid = 1'b1; addr = 32'h0000_0200; beats = 0; n = 0;
    while (beats < WORDS && n < 100) begin
      @(negedge clk);
      n++;
      flush = 1'b0;
      chk("refill_ready_low", 32'(ready), 32'd0);
      if (mem_valid && mem_ready) begin
        beats++;
        if (beats == 2) flush = 1'b1;
        if (beats == WORDS) valid = 1'b0;
      end
    end
    chk("flush_refill_beats", 32'(beats), 32'(WORDS));
    @(posedge clk); #1;
    fetch(32'h0000_0200, ZW_STALL, 32'hA5A5_0200, 32'd7);
    fetch(32'h0000_0100, ZW_STALL, 32'hA5A5_0100, 32'd8);

    // Reset on beat 2 of a refill
    valid = 1'b1; addr = 32'h0000_0400; beats = 0; n = 0;
    while (beats < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_valid && mem_ready) begin
        beats++;
        if (beats == 3) rst = 1'b1;
      end
    end
    chk("rst_refill_reached", 32'(beats), 32'd3);
    @(negedge clk);
    chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst_miss_cnt", miss_cnt, 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(32'h0000_0400, ZW_STALL, 32'hA5A5_0400, 32'd1);
    fetch(32'h0000_040C, 0, 32'hA5A5_040C, 32'd1);

    valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
